// File: rtl/game_over_ctrl_if.sv
// Signal bundle between the game-state logic, the end-of-round controller and the overlay/reset fan-out.
// The master modport is the controller's view; the slave modport is the surrounding game's view.
interface game_over_ctrl_if;
   logic       frame_tick;
   logic       p1_dead;
   logic       p2_dead;
   logic       btn_start;
   logic       game_over_screen;
   logic       freeze;
   logic       game_reset;
   logic [1:0] winner;
   logic       blink;

   modport master (
      input  frame_tick, p1_dead, p2_dead, btn_start,
      output game_over_screen, freeze, game_reset, winner, blink
   );

   modport slave (
      output frame_tick, p1_dead, p2_dead, btn_start,
      input  game_over_screen, freeze, game_reset, winner, blink
   );
endinterface

// File: rtl/game_over_ctrl.sv
// End-of-round sequencer: death detection, death-animation delay, game-over overlay with blinking
// banner, and a start-button restart that emits a single game_reset pulse.
module game_over_ctrl #(
   parameter int DEATH_FRAMES    = 90,
   parameter int MIN_SHOW_FRAMES = 60,
   parameter int BLINK_FRAMES    = 30
) (
   input  logic          clk,
   input  logic          rst_n,
   game_over_ctrl_if.master bus
);
   localparam int MAX_A = (DEATH_FRAMES > MIN_SHOW_FRAMES) ? DEATH_FRAMES : MIN_SHOW_FRAMES;
   localparam int MAX_F = (MAX_A > BLINK_FRAMES) ? MAX_A : BLINK_FRAMES;
   localparam int CNT_W = $clog2(MAX_F + 1);

   localparam logic [CNT_W-1:0] DEATH_LD = CNT_W'(DEATH_FRAMES);
   localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(MIN_SHOW_FRAMES);
   localparam logic [CNT_W-1:0] BLINK_LD = CNT_W'(BLINK_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   typedef enum logic [2:0] {
      PLAY    = 3'd0,
      DYING   = 3'd1,
      SHOW    = 3'd2,
      ARMED   = 3'd3,
      RESTART = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic [1:0]       winner_q, winner_d;
   logic             blink_q, blink_d;
   logic             skip_q, skip_d;
   logic             gos_q, freeze_q, reset_q;
   logic             overlay_d;

   // Counters only ever step down from a nonzero value; zero is sticky.
   function automatic logic [CNT_W-1:0] dec_nz(input logic [CNT_W-1:0] v);
      return (v != CNT_ZERO) ? (v - CNT_ONE) : v;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bcnt_d   = bcnt_q;
      winner_d = winner_q;
      blink_d  = blink_q;
      skip_d   = 1'b0;

      case (state_q)
         PLAY: begin
            // skip_q masks death flags while game_reset is still reaching the map and players
            if (!skip_q && (bus.p1_dead || bus.p2_dead)) begin
               winner_d = {bus.p1_dead, bus.p2_dead};
               cnt_d    = DEATH_LD;
               state_d  = DYING;
            end
         end
         DYING: begin
            if ((winner_q == 2'b10 && bus.p2_dead) || (winner_q == 2'b01 && bus.p1_dead))
               winner_d = 2'b11;
            if (bus.frame_tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d = SHOW;
                  cnt_d   = SHOW_LD;
                  bcnt_d  = BLINK_LD;
                  blink_d = 1'b0;
               end else begin
                  cnt_d = dec_nz(cnt_q);
               end
            end
         end
         SHOW: begin
            if (bus.frame_tick)
               cnt_d = dec_nz(cnt_q);
            if (cnt_q == CNT_ZERO && !bus.btn_start)
               state_d = ARMED;
         end
         ARMED: begin
            if (bus.btn_start)
               state_d = RESTART;
         end
         RESTART: begin
            state_d  = PLAY;
            winner_d = 2'b00;
            skip_d   = 1'b1;
         end
         default: state_d = PLAY;
      endcase

      // Banner blink runs only while the overlay is up; on SHOW entry the reload above wins.
      if ((state_q == SHOW || state_q == ARMED) && bus.frame_tick) begin
         if (bcnt_q == CNT_ONE) begin
            blink_d = ~blink_q;
            bcnt_d  = BLINK_LD;
         end else begin
            bcnt_d = dec_nz(bcnt_q);
         end
      end

      overlay_d = (state_d == SHOW) || (state_d == ARMED);
      if (!overlay_d)
         blink_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= PLAY;
         cnt_q    <= CNT_ZERO;
         bcnt_q   <= CNT_ZERO;
         winner_q <= 2'b00;
         blink_q  <= 1'b0;
         skip_q   <= 1'b0;
         gos_q    <= 1'b0;
         freeze_q <= 1'b0;
         reset_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcnt_q   <= bcnt_d;
         winner_q <= winner_d;
         blink_q  <= blink_d;
         skip_q   <= skip_d;
         gos_q    <= overlay_d;
         freeze_q <= overlay_d || (state_d == RESTART);
         reset_q  <= (state_d == RESTART);
      end
   end

   assign bus.game_over_screen = gos_q;
   assign bus.freeze           = freeze_q;
   assign bus.game_reset       = reset_q;
   assign bus.winner           = winner_q;
   assign bus.blink            = blink_q;
endmodule

// File: tb/tb_game_over_ctrl.sv
// Directed bench for game_over_ctrl: an up-counting phase model is compared against the DUT on every
// falling edge, and literal expectations at key points pin the model to hand-derived values.
module tb_game_over_ctrl;
   localparam int DF = 3;
   localparam int MS = 2;
   localparam int BF = 1;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   game_over_ctrl_if bus ();

   game_over_ctrl #(
      .DEATH_FRAMES   (DF),
      .MIN_SHOW_FRAMES(MS),
      .BLINK_FRAMES   (BF)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 play, 1 dying, 2 show, 3 armed, 4 restart; ticks count up from phase entry.
   int   m_phase = 0;
   int   m_ticks = 0;
   int   m_bticks = 0;
   int   m_winner = 0;
   bit   m_blink = 0;
   bit   m_skip = 0;
   bit   m_valid = 0;

   always @(posedge clk) begin
      int old_ticks;
      bit p1, p2, tk, bt, surv;
      int prev;
      p1 = bus.p1_dead; p2 = bus.p2_dead; tk = bus.frame_tick; bt = bus.btn_start;
      if (!rst_n) begin
         m_phase = 0; m_ticks = 0; m_bticks = 0; m_winner = 0; m_blink = 0; m_skip = 0;
         m_valid = 1;
      end else begin
         prev = m_phase;
         old_ticks = m_ticks;
         case (m_phase)
            0: begin
               if (!m_skip && (p1 || p2)) begin
                  if (p1 && p2)  m_winner = 3;
                  else if (p1)   m_winner = 2;
                  else           m_winner = 1;
                  m_phase = 1;
                  m_ticks = 0;
               end
               m_skip = 0;
            end
            1: begin
               surv = (m_winner == 2) ? p2 : (m_winner == 1) ? p1 : 1'b0;
               if (surv) m_winner = 3;
               if (tk) begin
                  m_ticks++;
                  if (m_ticks == DF) begin
                     m_phase = 2; m_ticks = 0; m_bticks = 0; m_blink = 0;
                  end
               end
            end
            2: begin
               if (tk && m_ticks < MS) m_ticks++;
               if (old_ticks == MS && !bt) m_phase = 3;
            end
            3: if (bt) m_phase = 4;
            default: begin
               m_phase = 0; m_winner = 0; m_skip = 1;
            end
         endcase
         if ((prev == 2 || prev == 3) && tk) begin
            m_bticks++;
            if (m_bticks == BF) begin
               m_blink = ~m_blink;
               m_bticks = 0;
            end
         end
         if (m_phase != 2 && m_phase != 3) m_blink = 0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_overlay", int'(bus.game_over_screen), int'(m_phase == 2 || m_phase == 3));
         chk("model_freeze",  int'(bus.freeze),           int'(m_phase >= 2));
         chk("model_reset",   int'(bus.game_reset),       int'(m_phase == 4));
         chk("model_winner",  int'(bus.winner),           m_winner);
         chk("model_blink",   int'(bus.blink),            int'(m_blink));
      end
   end

   task automatic cyc(input logic t);
      bus.frame_tick = t;
      @(posedge clk);
      #2;
      bus.frame_tick = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_overlay"}, int'(bus.game_over_screen), 0);
      chk({tag, "_freeze"},  int'(bus.freeze),           0);
      chk({tag, "_reset"},   int'(bus.game_reset),       0);
      chk({tag, "_winner"},  int'(bus.winner),           0);
      chk({tag, "_blink"},   int'(bus.blink),            0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.frame_tick = 1'b0; bus.p1_dead = 1'b0; bus.p2_dead = 1'b0; bus.btn_start = 1'b0;
      cyc(0); cyc(0);
      chk_all_zero("reset");

      // P2 dies alone: P1 wins, overlay after the third tick
      rst_n = 1'b1;
      cyc(0);
      bus.p2_dead = 1'b1;
      cyc(0);
      chk("p2_winner", int'(bus.winner), 1);
      chk("dying_freeze", int'(bus.freeze), 0);
      cyc(1); cyc(0); cyc(1);
      chk("before_3rd_tick", int'(bus.game_over_screen), 0);
      cyc(1);
      chk("overlay_up", int'(bus.game_over_screen), 1);
      chk("freeze_up", int'(bus.freeze), 1);
      bus.p2_dead = 1'b0;

      // Button held across expiry is ignored; blink toggles every tick
      bus.btn_start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         chk("held_no_reset", int'(bus.game_reset), 0);
         chk("blink_toggle", int'(bus.blink), k % 2);
      end
      bus.btn_start = 1'b0;
      cyc(0); cyc(0);
      chk("armed_overlay", int'(bus.game_over_screen), 1);
      bus.btn_start = 1'b1;
      cyc(0);
      chk("restart_pulse", int'(bus.game_reset), 1);
      chk("restart_overlay", int'(bus.game_over_screen), 0);
      chk("restart_freeze", int'(bus.freeze), 1);
      chk("restart_blink", int'(bus.blink), 0);
      bus.btn_start = 1'b0;
      cyc(0);
      chk_all_zero("after_restart");

      // Death in the first PLAY cycle is masked; second death during DYING makes a draw
      bus.p1_dead = 1'b1;
      cyc(0);
      chk("masked_death", int'(bus.winner), 0);
      cyc(0);
      chk("p1_winner", int'(bus.winner), 2);
      cyc(1);
      bus.p2_dead = 1'b1;
      cyc(0);
      chk("draw_winner", int'(bus.winner), 3);
      cyc(1);
      chk("draw_before_3rd", int'(bus.game_over_screen), 0);
      cyc(1);
      chk("draw_overlay", int'(bus.game_over_screen), 1);
      chk("draw_winner_held", int'(bus.winner), 3);
      bus.p1_dead = 1'b0; bus.p2_dead = 1'b0;

      // Reset while ARMED aborts with no game_reset pulse
      cyc(1); cyc(1); cyc(0);
      chk("armed_again", int'(bus.game_over_screen), 1);
      rst_n = 1'b0;
      cyc(0);
      chk_all_zero("mid_reset");
      rst_n = 1'b1;

      // Death with a coincident tick: that tick is not counted
      bus.p1_dead = 1'b1;
      cyc(1);
      bus.p1_dead = 1'b0;
      chk("tick_death_winner", int'(bus.winner), 2);
      cyc(1); cyc(1);
      chk("tick_not_counted", int'(bus.game_over_screen), 0);
      cyc(1);
      chk("tick_overlay", int'(bus.game_over_screen), 1);
      cyc(0); cyc(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
